// File: rtl/mac_unit.sv
// ---------------------------------------------------------------------------
// mac_unit
//
// Single multiply-accumulate lane for the matrix accelerator. On each enabled
// clock edge one A element is multiplied by one B element and the product is
// added to an internal accumulator. Asserting clear together with enable
// starts a new dot product that already contains its first term. Several
// lanes run in parallel and their accum_out values are summed outside this
// block to form one C element.
//
// Ports:
//   clk        in   1           rising-edge clock
//   reset      in   1           asynchronous, active-low reset (0 clears acc)
//   clear      in   1           synchronous restart of the accumulation
//   enable     in   1           synchronous accumulate strobe
//   a_in       in   DATA_WIDTH  multiplicand (A element)
//   b_in       in   DATA_WIDTH  multiplier (B element)
//   accum_out  out  DATA_WIDTH  registered accumulator value
// ---------------------------------------------------------------------------
module mac_unit #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear,
  input  logic                  enable,
  input  logic [DATA_WIDTH-1:0] a_in,
  input  logic [DATA_WIDTH-1:0] b_in,
  output logic [DATA_WIDTH-1:0] accum_out
);

  // Only the low DATA_WIDTH product bits are kept. They are identical for
  // signed and unsigned operands, so the lane does not care about signedness.
  logic [DATA_WIDTH-1:0] w_product;
  logic [DATA_WIDTH-1:0] w_sum;
  logic [DATA_WIDTH-1:0] r_acc;

  assign w_product = a_in * b_in;

  // The sum wraps modulo 2^DATA_WIDTH; there is no saturation or overflow flag.
  assign w_sum = r_acc + w_product;

  // Accumulator register. clear has priority over accumulation; clear with
  // enable loads the product directly so a new dot product loses no cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_acc <= '0;
    end else if (clear) begin
      r_acc <= enable ? w_product : '0;
    end else if (enable) begin
      r_acc <= w_sum;
    end
  end

  assign accum_out = r_acc;

endmodule

// File: tb/tb_mac_unit.sv
// ---------------------------------------------------------------------------
// tb_mac_unit
//
// Directed self-checking bench for mac_unit. Each step drives one set of
// inputs on the falling edge and pushes the hand-computed accumulator value
// into a scoreboard queue; after the next rising edge the value is popped and
// compared against accum_out.
// ---------------------------------------------------------------------------
module tb_mac_unit;

  localparam int DW = 32;

  logic          clk;
  logic          reset;
  logic          clear;
  logic          enable;
  logic [DW-1:0] a_in;
  logic [DW-1:0] b_in;
  logic [DW-1:0] accum_out;

  logic [DW-1:0] expQueue[$];
  int            errors;
  int            checks;

  mac_unit #(.DATA_WIDTH(DW)) dut (
    .clk       (clk),
    .reset     (reset),
    .clear     (clear),
    .enable    (enable),
    .a_in      (a_in),
    .b_in      (b_in),
    .accum_out (accum_out)
  );

  // Free-running 100 MHz clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Guard against a run that never finishes.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Pop the oldest expected value and compare it with accum_out.
  task automatic checkOutput(input string tag);
    logic [DW-1:0] expVal;
    checks++;
    if (expQueue.size() == 0) begin
      errors++;
      $error("[TB] FAIL %s: observed=%h required=<scoreboard entry>", tag, accum_out);
    end else begin
      expVal = expQueue.pop_front();
      assert (accum_out === expVal) else begin
        errors++;
        $error("[TB] FAIL %s: observed=%h required=%h", tag, accum_out, expVal);
      end
    end
  endtask

  // Drive one clocked step on the falling edge, record the required result,
  // and sample just after the following rising edge.
  task automatic applyStimulus(input logic clr, input logic en,
                               input logic [DW-1:0] a, input logic [DW-1:0] b,
                               input logic [DW-1:0] expVal, input string tag);
    @(negedge clk);
    clear  = clr;
    enable = en;
    a_in   = a;
    b_in   = b;
    expQueue.push_back(expVal);
    @(posedge clk);
    #1;
    checkOutput(tag);
  endtask

  // Three-term dot product (1,4)+(2,5)+(3,6) giving 4, 14, 32.
  task automatic dotProduct(input string tag);
    applyStimulus(1'b1, 1'b1, 32'd1, 32'd4, 32'd4,  {tag, "_t1"});
    applyStimulus(1'b0, 1'b1, 32'd2, 32'd5, 32'd14, {tag, "_t2"});
    applyStimulus(1'b0, 1'b1, 32'd3, 32'd6, 32'd32, {tag, "_t3"});
  endtask

  initial begin
    errors = 0;
    checks = 0;
    reset  = 1'b0;
    clear  = 1'b0;
    enable = 1'b0;
    a_in   = '0;
    b_in   = '0;

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    expQueue.push_back(32'd0);
    checkOutput("reset_state");
    @(negedge clk);
    reset = 1'b1;

    // Asynchronous reset in the middle of a cycle, no clock edge involved.
    applyStimulus(1'b1, 1'b1, 32'h0000_1234, 32'd1, 32'h0000_1234, "load_1234");
    #3;
    reset  = 1'b0;
    clear  = 1'b0;
    enable = 1'b0;
    #1;
    expQueue.push_back(32'd0);
    checkOutput("async_reset");
    @(negedge clk);
    reset = 1'b1;
    applyStimulus(1'b0, 1'b0, $urandom, $urandom, 32'd0, "post_reset_idle");

    // Clear-and-load, then plain clear.
    applyStimulus(1'b1, 1'b1, 32'd99, 32'd1, 32'd99, "load_99");
    applyStimulus(1'b1, 1'b1, 32'd3,  32'd4, 32'd12, "clear_load_12");
    applyStimulus(1'b1, 1'b0, $urandom, $urandom, 32'd0, "clear_only");

    // Dot product followed by five hold cycles with random operands.
    dotProduct("dot");
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, 1'b0, $urandom, $urandom, 32'd32, $sformatf("hold_%0d", i));
    end

    // Signed operands, discarded upper product bits and modular wrap.
    applyStimulus(1'b1, 1'b1, 32'hFFFF_FFFF, 32'd5, 32'hFFFF_FFFB, "neg_one_x5");
    applyStimulus(1'b0, 1'b1, 32'h8000_0000, 32'd2, 32'hFFFF_FFFB, "upper_bits_dropped");
    applyStimulus(1'b0, 1'b1, 32'd1,         32'd5, 32'h0000_0000, "wrap_to_zero");

    // Clear has priority over accumulation.
    applyStimulus(1'b1, 1'b1, 32'd100, 32'd1, 32'd100, "load_100");
    applyStimulus(1'b1, 1'b1, 32'd7,   32'd7, 32'd49,  "priority_49");

    // Back-to-back dot products with no idle cycle in between.
    dotProduct("b2b_first");
    dotProduct("b2b_second");

    // Reset in the middle of an accumulation restarts from zero.
    applyStimulus(1'b0, 1'b1, 32'd2, 32'd2, 32'd36, "accum_36");
    @(negedge clk);
    reset  = 1'b0;
    clear  = 1'b0;
    enable = 1'b0;
    #2;
    reset  = 1'b1;
    applyStimulus(1'b0, 1'b1, 32'd3, 32'd3, 32'd9, "restart_after_reset");

    if (expQueue.size() != 0) begin
      errors++;
      $error("[TB] FAIL scoreboard_drain: observed=%0d required=0", expQueue.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
